// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg: shared receiver state enum and default screen/pixel constants
package pixel_stream_pkg;
  typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DROP_LINE} rx_state_t;
  localparam int DEF_SCREEN_WIDTH = 640;
  localparam int DEF_SCREEN_HEIGHT = 480;
  localparam int DEF_RGB_SIZE = 24;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating counter (clk, reset, clr zeroes and beats inc, inc adds one, cnt value)
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= (reset || clr) ? '0 : (inc && !(&cnt)) ? cnt + CNT_WIDTH'(1) : cnt;
endmodule

// File: rtl/pixel_stream_receiver.sv
// pixel_stream_receiver: valid/ready pixel sink rebuilding x/y from sof/eol, resyncing on framing errors; out_* is a one-deep registered stage, err_*/drop_cnt are saturating debug counters
module pixel_stream_receiver
  import pixel_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RGB_SIZE = DEF_RGB_SIZE,
  parameter int SCREEN_WIDTH = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RGB_SIZE-1:0]   in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic                  in_eol,
  output logic                  in_ready,
  output logic [RGB_SIZE-1:0]   out_data,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  in_sync,
  input  logic                  clr_counters,
  output logic [CNT_WIDTH-1:0]  err_sof_cnt,
  output logic [CNT_WIDTH-1:0]  err_eol_early_cnt,
  output logic [CNT_WIDTH-1:0]  err_eol_late_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);
  localparam logic [DATA_WIDTH-1:0] LX = DATA_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] LY = DATA_WIDTH'(SCREEN_HEIGHT - 1);
  rx_state_t st, st_n;
  logic [DATA_WIDTH-1:0] x, y, x_n, y_n, cx, cy;
  logic acc, fwd, e_sof, e_early, e_late, done;
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  assign in_sync = st == ACTIVE;
  // sof restarts the position before any eol checks, so it is processed as pixel (0,0)
  assign cx = in_sof ? '0 : x;
  assign cy = in_sof ? '0 : y;
  always_comb begin
    st_n = st;
    x_n = x;
    y_n = y;
    fwd = 1'b0;
    e_sof = 1'b0;
    e_early = 1'b0;
    e_late = 1'b0;
    done = 1'b0;
    if (acc) begin
      fwd = in_sof || st == ACTIVE;
      e_sof = in_sof && st != WAIT_SOF;
      if (fwd && !in_eol && cx == LX) begin
        e_late = 1'b1;
        st_n = DROP_LINE;
        x_n = cx;
        y_n = cy;
      end else if (fwd && !in_eol) begin
        st_n = ACTIVE;
        x_n = cx + DATA_WIDTH'(1);
        y_n = cy;
      end else if (fwd || (st == DROP_LINE && in_eol)) begin
        e_early = fwd && cx != LX;
        done = cy == LY;
        st_n = done ? WAIT_SOF : ACTIVE;
        x_n = '0;
        y_n = done ? '0 : cy + DATA_WIDTH'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= WAIT_SOF;
      x <= '0;
      y <= '0;
    end else begin
      st <= st_n;
      x <= x_n;
      y <= y_n;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_x <= '0;
      out_y <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done;
      if (fwd) begin
        out_valid <= 1'b1;
        out_data <= in_data;
        out_x <= cx;
        out_y <= cy;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_sof (.clk(clk), .reset(reset), .clr(clr_counters), .inc(e_sof), .cnt(err_sof_cnt));
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_early (.clk(clk), .reset(reset), .clr(clr_counters), .inc(e_early), .cnt(err_eol_early_cnt));
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_late (.clk(clk), .reset(reset), .clr(clr_counters), .inc(e_late), .cnt(err_eol_late_cnt));
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop (.clk(clk), .reset(reset), .clr(clr_counters), .inc(acc && !fwd), .cnt(drop_cnt));
endmodule

// File: tb/tb_pixel_stream_receiver.sv
// tb_pixel_stream_receiver: scoreboard bench for pixel_stream_receiver at a 4x3 screen
module tb_pixel_stream_receiver;
  localparam int W = 4;
  localparam int H = 3;
  typedef struct packed {
    logic [23:0] d;
    logic [31:0] x;
    logic [31:0] y;
  } exp_t;
  logic clk = 0, reset = 1;
  logic [23:0] in_data = 0;
  logic in_valid = 0, in_sof = 0, in_eol = 0, in_ready;
  logic [23:0] out_data;
  logic [31:0] out_x, out_y;
  logic out_valid, out_ready = 1, frame_done, in_sync, clr_counters = 0;
  logic [15:0] err_sof_cnt, err_eol_early_cnt, err_eol_late_cnt, drop_cnt;
  exp_t q[$];
  int checks = 0, errors = 0, fd_cnt = 0;
  logic rand_rdy = 0;
  pixel_stream_receiver #(.DATA_WIDTH(32), .RGB_SIZE(24), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol),
    .in_ready(in_ready), .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_valid(out_valid),
    .out_ready(out_ready), .frame_done(frame_done), .in_sync(in_sync), .clr_counters(clr_counters),
    .err_sof_cnt(err_sof_cnt), .err_eol_early_cnt(err_eol_early_cnt), .err_eol_late_cnt(err_eol_late_cnt),
    .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done) fd_cnt++;
  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL in_ready: got %b, want %b (out_valid=%b out_ready=%b)", in_ready, !out_valid || out_ready, out_valid, out_ready);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got d=%h x=%0d y=%0d, want nothing", out_data, out_x, out_y);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (out_data !== e.d || out_x !== e.x || out_y !== e.y) begin
            errors++;
            $display("FAIL out_beat: got d=%h x=%0d y=%0d, want d=%h x=%0d y=%0d", out_data, out_x, out_y, e.d, e.x, e.y);
          end
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask
  task automatic send(input logic [23:0] d, input logic sof, input logic eol, input logic fw, input int ex, input int ey);
    int n = 0;
    in_data = d;
    in_sof = sof;
    in_eol = eol;
    in_valid = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, want 1", n);
    end else if (fw) q.push_back('{d, 32'(ex), 32'(ey)});
    @(posedge clk);
    #1;
    in_valid = 0;
    in_sof = 0;
    in_eol = 0;
  endtask
  task automatic frame(input int base, input int start);
    for (int i = start; i < W * H; i++) send(24'(base + i), i == 0, i % W == W - 1, 1, i % W, i / W);
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_pending", q.size(), 0);
  endtask
  task automatic clr();
    clr_counters = 1;
    @(posedge clk);
    #1;
    clr_counters = 0;
  endtask
  initial begin
    int f0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_in_sync", in_sync, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_out_xy", out_x | out_y, 0);
    chk("rst_drop", drop_cnt, 0);
    reset = 0;
    frame(24'h100, 0);
    chk("t1_frame_done", frame_done, 1);
    drain();
    chk("t1_errs", err_sof_cnt + err_eol_early_cnt + err_eol_late_cnt + drop_cnt, 0);
    chk("t1_in_sync", in_sync, 0);
    for (int i = 0; i < 3; i++) send(24'(i), 0, 0, 0, 0, 0);
    chk("t2_sync_low", in_sync, 0);
    send(24'h200, 1, 0, 1, 0, 0);
    chk("t2_sync_high", in_sync, 1);
    frame(24'h200, 1);
    drain();
    chk("t2_drop", drop_cnt, 3);
    clr();
    chk("clr_drop", drop_cnt, 0);
    f0 = fd_cnt;
    send(24'h300, 1, 0, 1, 0, 0);
    send(24'h301, 0, 1, 1, 1, 0);
    for (int i = 0; i < 8; i++) send(24'(24'h310 + i), 0, i % 4 == 3, 1, i % 4, 1 + i / 4);
    drain();
    chk("t3_early", err_eol_early_cnt, 1);
    chk("t3_done", fd_cnt - f0, 1);
    clr();
    for (int i = 0; i < 4; i++) send(24'(24'h400 + i), i == 0, i == 3, 1, i, 0);
    for (int i = 0; i < 4; i++) send(24'(24'h410 + i), 0, 0, 1, i, 1);
    send(24'h420, 0, 0, 0, 0, 0);
    send(24'h421, 0, 0, 0, 0, 0);
    send(24'h422, 0, 1, 0, 0, 0);
    chk("t4_sync_back", in_sync, 1);
    for (int i = 0; i < 4; i++) send(24'(24'h430 + i), 0, i == 3, 1, i, 2);
    drain();
    chk("t4_late", err_eol_late_cnt, 1);
    chk("t4_drop", drop_cnt, 3);
    clr();
    for (int i = 0; i < 4; i++) send(24'(24'h500 + i), i == 0, i == 3, 1, i, 0);
    send(24'h510, 0, 0, 1, 0, 1);
    send(24'h511, 0, 0, 1, 1, 1);
    send(24'h512, 1, 0, 1, 0, 0);
    frame(24'h512, 1);
    drain();
    chk("t5_sof", err_sof_cnt, 1);
    chk("t5_others", err_eol_early_cnt + err_eol_late_cnt + drop_cnt, 0);
    f0 = fd_cnt;
    rand_rdy = 1;
    frame(24'h600, 0);
    frame(24'h700, 0);
    rand_rdy = 0;
    @(posedge clk);
    #2;
    out_ready = 1;
    drain();
    chk("t6_done", fd_cnt - f0, 2);
    out_ready = 0;
    send(24'h800, 1, 0, 1, 0, 0);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    q.delete();
    chk("t7_out_valid", out_valid, 0);
    chk("t7_in_sync", in_sync, 0);
    out_ready = 1;
    send(24'h801, 0, 0, 0, 0, 0);
    chk("t7_drop", drop_cnt, 1);
    frame(24'h900, 0);
    drain();
    chk("t7_drop_end", drop_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
